// File: rtl/sobel_window_gen.sv
// sobel_window_gen: raster-order luma stream -> 3x3 neighbourhood windows for the Sobel core.
// Build option SOBEL_WINDOW_REPLICATE_BORDER_EN: edge-replicated borders instead of zero padding.
module sobel_window_gen #(
   parameter int unsigned H_PIXELS = 640,
   parameter int unsigned V_LINES  = 480,
   parameter int unsigned CNT_W    = 10
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [7:0]       pix_in,
   input  logic             pix_valid,
   output logic             pix_ready,
   output logic [63:0]      win_pixels,
   output logic [CNT_W-1:0] win_row,
   output logic [CNT_W-1:0] win_col,
   output logic             win_valid,
   input  logic             win_ready,
   output logic             frame_done
);

   localparam int unsigned PIX_W  = 8;
   localparam int unsigned COL_W  = 3 * PIX_W;
   localparam int unsigned WIN_W  = 8 * PIX_W;
   localparam int unsigned ADDR_W = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;

   localparam logic [CNT_W-1:0] COL_LAST   = CNT_W'(H_PIXELS - 1);
   localparam logic [CNT_W-1:0] ROW_LAST   = CNT_W'(V_LINES - 1);
   localparam logic [CNT_W-1:0] ROW_PENULT = CNT_W'(V_LINES - 2);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FILL  = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_EOL   = 3'd3;
   localparam logic [2:0] S_FLUSH = 3'd4;

`ifdef SOBEL_WINDOW_REPLICATE_BORDER_EN
   localparam bit REPLICATE = 1'b1;
`else
   localparam bit REPLICATE = 1'b0;
`endif

   // Column vectors are {top, mid, bottom} bytes of one image column.
   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] row_q, row_d;
   logic [CNT_W-1:0] col_q, col_d;
   logic             mid_sel_q, mid_sel_d;
   logic             flush_last_q, flush_last_d;
   logic             last_win_q, last_win_d;
   logic [COL_W-1:0] ca_q, ca_d;
   logic [COL_W-1:0] cb_q, cb_d;
   logic [WIN_W-1:0] win_pixels_q, win_pixels_d;
   logic [CNT_W-1:0] win_row_q, win_row_d;
   logic [CNT_W-1:0] win_col_q, win_col_d;
   logic             win_valid_q, win_valid_d;
   logic             frame_done_q, frame_done_d;

   logic [PIX_W-1:0] lb0_q [H_PIXELS];
   logic [PIX_W-1:0] lb1_q [H_PIXELS];

   logic [ADDR_W-1:0] addr_c;
   logic [PIX_W-1:0]  rd_top_c, rd_mid_c, top_c, bot_c;
   logic [COL_W-1:0]  new_col_c, west_c, pad_side_c;
   logic              out_free_c, accept_c;
   logic              lb_we_c, lb_wsel_c;

   function automatic logic [WIN_W-1:0] pack_win(input logic [COL_W-1:0] w,
                                                 input logic [PIX_W-1:0] c_top,
                                                 input logic [PIX_W-1:0] c_bot,
                                                 input logic [COL_W-1:0] e);
      return {w[23:16], c_top, e[23:16], w[15:8], e[15:8], w[7:0], c_bot, e[7:0]};
   endfunction

   assign out_free_c = !win_valid_q || win_ready;
   assign pix_ready  = ((state_q == S_FILL) || (state_q == S_RUN)) && out_free_c;
   assign accept_c   = pix_valid && pix_ready;

   // Line-buffer read of the current column and border substitution.
   always_comb begin
      addr_c     = col_q[ADDR_W-1:0];
      rd_mid_c   = mid_sel_q ? lb1_q[addr_c] : lb0_q[addr_c];
      rd_top_c   = mid_sel_q ? lb0_q[addr_c] : lb1_q[addr_c];
      top_c      = (row_q == '0) ? (REPLICATE ? rd_mid_c : '0) : rd_top_c;
      bot_c      = (state_q == S_FLUSH) ? (REPLICATE ? rd_mid_c : '0) : pix_in;
      new_col_c  = {top_c, rd_mid_c, bot_c};
      pad_side_c = REPLICATE ? ca_q : '0;
      west_c     = (col_q == CNT_W'(1)) ? pad_side_c : cb_q;
   end

   always_comb begin
      state_d      = state_q;
      row_d        = row_q;
      col_d        = col_q;
      mid_sel_d    = mid_sel_q;
      flush_last_d = flush_last_q;
      last_win_d   = last_win_q;
      ca_d         = ca_q;
      cb_d         = cb_q;
      win_pixels_d = win_pixels_q;
      win_row_d    = win_row_q;
      win_col_d    = win_col_q;
      win_valid_d  = win_valid_q;
      frame_done_d = win_valid_q && win_ready && last_win_q;
      lb_we_c      = 1'b0;
      lb_wsel_c    = mid_sel_q;

      if (win_valid_q && win_ready) win_valid_d = 1'b0;

      case (state_q)
         S_FILL: begin
            if (accept_c) begin
               lb_we_c   = 1'b1;
               lb_wsel_c = mid_sel_q;
               if (col_q == COL_LAST) begin
                  col_d   = '0;
                  state_d = S_RUN;
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         S_RUN: begin
            if (accept_c) begin
               lb_we_c   = 1'b1;
               lb_wsel_c = ~mid_sel_q;
               ca_d      = new_col_c;
               cb_d      = ca_q;
               if (col_q != '0) begin
                  win_pixels_d = pack_win(west_c, ca_q[23:16], ca_q[7:0], new_col_c);
                  win_row_d    = row_q;
                  win_col_d    = col_q - 1'b1;
                  win_valid_d  = 1'b1;
                  last_win_d   = 1'b0;
               end
               if (col_q == COL_LAST) begin
                  col_d   = '0;
                  state_d = S_EOL;
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         S_EOL: begin
            // Last column of the line; the rotated buffers become rows r and r+1.
            if (out_free_c) begin
               win_pixels_d = pack_win(cb_q, ca_q[23:16], ca_q[7:0], pad_side_c);
               win_row_d    = row_q;
               win_col_d    = COL_LAST;
               win_valid_d  = 1'b1;
               last_win_d   = 1'b0;
               mid_sel_d    = ~mid_sel_q;
               if (row_q == ROW_PENULT) begin
                  row_d   = ROW_LAST;
                  state_d = S_FLUSH;
               end else begin
                  row_d   = row_q + 1'b1;
                  state_d = S_RUN;
               end
            end
         end
         S_FLUSH: begin
            if (out_free_c) begin
               if (flush_last_q) begin
                  win_pixels_d = pack_win(cb_q, ca_q[23:16], ca_q[7:0], pad_side_c);
                  win_row_d    = row_q;
                  win_col_d    = COL_LAST;
                  win_valid_d  = 1'b1;
                  last_win_d   = 1'b1;
                  flush_last_d = 1'b0;
                  row_d        = '0;
                  col_d        = '0;
                  state_d      = S_IDLE;
               end else begin
                  ca_d = new_col_c;
                  cb_d = ca_q;
                  if (col_q != '0) begin
                     win_pixels_d = pack_win(west_c, ca_q[23:16], ca_q[7:0], new_col_c);
                     win_row_d    = row_q;
                     win_col_d    = col_q - 1'b1;
                     win_valid_d  = 1'b1;
                     last_win_d   = 1'b0;
                  end
                  if (col_q == COL_LAST) begin
                     col_d        = '0;
                     flush_last_d = 1'b1;
                  end else begin
                     col_d = col_q + 1'b1;
                  end
               end
            end
         end
         default: begin
         end
      endcase

      // Start abandons the frame in progress, including any pending window.
      if (start) begin
         state_d      = S_FILL;
         row_d        = '0;
         col_d        = '0;
         flush_last_d = 1'b0;
         last_win_d   = 1'b0;
         win_valid_d  = 1'b0;
         frame_done_d = 1'b0;
         lb_we_c      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         row_q        <= '0;
         col_q        <= '0;
         mid_sel_q    <= 1'b0;
         flush_last_q <= 1'b0;
         last_win_q   <= 1'b0;
         ca_q         <= '0;
         cb_q         <= '0;
         win_pixels_q <= '0;
         win_row_q    <= '0;
         win_col_q    <= '0;
         win_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         col_q        <= col_d;
         mid_sel_q    <= mid_sel_d;
         flush_last_q <= flush_last_d;
         last_win_q   <= last_win_d;
         ca_q         <= ca_d;
         cb_q         <= cb_d;
         win_pixels_q <= win_pixels_d;
         win_row_q    <= win_row_d;
         win_col_q    <= win_col_d;
         win_valid_q  <= win_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Line buffers hold no reset state; contents are rewritten before use.
   always_ff @(posedge clk) begin
      if (lb_we_c) begin
         if (lb_wsel_c) lb1_q[addr_c] <= pix_in;
         else           lb0_q[addr_c] <= pix_in;
      end
   end

   assign win_pixels = win_pixels_q;
   assign win_row    = win_row_q;
   assign win_col    = win_col_q;
   assign win_valid  = win_valid_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// tb_sobel_window_gen: directed checks of sobel_window_gen on a 4x3 image with p(r,c)=16r+c+1.
module tb_sobel_window_gen;

   localparam int H    = 4;
   localparam int V    = 3;
   localparam int CW   = 10;
   localparam int NWIN = H * V;

`ifdef SOBEL_WINDOW_REPLICATE_BORDER_EN
   localparam logic [63:0] EXP00 = 64'h0101020102111112;
   localparam logic [63:0] EXP11 = 64'h0102031113212223;
   localparam logic [63:0] EXP23 = 64'h1314142324232424;
`else
   localparam logic [63:0] EXP00 = 64'h0000000002001112;
   localparam logic [63:0] EXP11 = 64'h0102031113212223;
   localparam logic [63:0] EXP23 = 64'h1314002300000000;
`endif

   logic          clk = 1'b0;
   logic          reset_n, start, pix_valid, win_ready;
   logic [7:0]    pix_in;
   logic          pix_ready, win_valid, frame_done;
   logic [63:0]   win_pixels;
   logic [CW-1:0] win_row, win_col;

   always #5 clk = ~clk;

   sobel_window_gen #(.H_PIXELS(H), .V_LINES(V), .CNT_W(CW)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .pix_in     (pix_in),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .win_pixels (win_pixels),
      .win_row    (win_row),
      .win_col    (win_col),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
      .frame_done (frame_done)
   );

   int            n_cmp = 0;
   int            n_err = 0;
   logic [63:0]   cap_pix [$];
   logic [CW-1:0] cap_row [$];
   logic [CW-1:0] cap_col [$];
   int            fd_cnt;
   int            fd_at;
   bit            stall_arm;

   function automatic logic [7:0] px(input int r, input int c);
      int rr, cc;
      rr = r;
      cc = c;
`ifdef SOBEL_WINDOW_REPLICATE_BORDER_EN
      if (rr < 0) rr = 0;
      if (rr > V - 1) rr = V - 1;
      if (cc < 0) cc = 0;
      if (cc > H - 1) cc = H - 1;
`else
      if (rr < 0 || rr > V - 1 || cc < 0 || cc > H - 1) return 8'h00;
`endif
      return 8'(16 * rr + cc + 1);
   endfunction

   function automatic logic [63:0] exp_win(input int r, input int c);
      return {px(r-1, c-1), px(r-1, c), px(r-1, c+1), px(r, c-1),
              px(r, c+1), px(r+1, c-1), px(r+1, c), px(r+1, c+1)};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // One clock: optional stall on window (1,2), then capture handshakes and frame_done.
   task automatic step();
      @(negedge clk);
      if (stall_arm && win_valid && win_row == CW'(1) && win_col == CW'(2)) begin
         stall_arm = 1'b0;
         win_ready = 1'b0;
         for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_valid", k), 64'(win_valid), 64'd1);
            chk($sformatf("stall%0d_pix", k), win_pixels, exp_win(1, 2));
            chk($sformatf("stall%0d_row", k), 64'(win_row), 64'd1);
            chk($sformatf("stall%0d_col", k), 64'(win_col), 64'd2);
            chk($sformatf("stall%0d_pix_ready", k), 64'(pix_ready), 64'd0);
         end
         win_ready = 1'b1;
         #1;
      end
      if (win_valid && win_ready) begin
         cap_pix.push_back(win_pixels);
         cap_row.push_back(win_row);
         cap_col.push_back(win_col);
      end
      if (frame_done) begin
         fd_cnt++;
         fd_at = cap_pix.size();
      end
   endtask

   task automatic clear_caps();
      cap_pix.delete();
      cap_row.delete();
      cap_col.delete();
      fd_cnt = 0;
      fd_at  = -1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic drive(input int npix, input int gap_pct);
      for (int i = 0; i < npix; i++) begin
         int  r, c, budget;
         bit  accepted;
         r = i / H;
         c = i % H;
         accepted = 1'b0;
         budget = 0;
         while (!accepted && budget < 200) begin
            if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
               pix_valid = 1'b0;
            end else begin
               pix_valid = 1'b1;
               pix_in    = 8'(16 * r + c + 1);
               accepted  = pix_ready;
            end
            step();
            budget++;
         end
         pix_valid = 1'b0;
         if (!accepted) begin
            chk($sformatf("accept_r%0d_c%0d", r, c), 64'(accepted), 64'd1);
            return;
         end
         if (c == H - 1 && r >= 1 && r <= V - 2) begin
            chk($sformatf("eol%0d_ready_lo", r), 64'(pix_ready), 64'd0);
            step();
            chk($sformatf("eol%0d_ready_hi", r), 64'(pix_ready), 64'd1);
         end
      end
   endtask

   task automatic drain();
      int budget;
      budget = 0;
      while (cap_pix.size() < NWIN && budget < 200) begin
         step();
         budget++;
      end
      repeat (3) step();
   endtask

   task automatic verify_frame(input string t);
      chk({t, "_count"}, 64'(cap_pix.size()), 64'(NWIN));
      for (int i = 0; i < cap_pix.size() && i < NWIN; i++) begin
         chk($sformatf("%s_w%0d_row", t, i), 64'(cap_row[i]), 64'(i / H));
         chk($sformatf("%s_w%0d_col", t, i), 64'(cap_col[i]), 64'(i % H));
         chk($sformatf("%s_w%0d_pix", t, i), cap_pix[i], exp_win(i / H, i % H));
      end
      if (cap_pix.size() == NWIN) begin
         chk({t, "_c00"}, cap_pix[0], EXP00);
         chk({t, "_c11"}, cap_pix[5], EXP11);
         chk({t, "_c23"}, cap_pix[11], EXP23);
      end
      chk({t, "_fd_cnt"}, 64'(fd_cnt), 64'd1);
      chk({t, "_fd_at"}, 64'(fd_at), 64'(NWIN));
   endtask

   task automatic chk_reset_outputs(input string t);
      chk({t, "_pix_ready"}, 64'(pix_ready), 64'd0);
      chk({t, "_win_valid"}, 64'(win_valid), 64'd0);
      chk({t, "_frame_done"}, 64'(frame_done), 64'd0);
      chk({t, "_win_pixels"}, win_pixels, 64'd0);
      chk({t, "_win_row"}, 64'(win_row), 64'd0);
      chk({t, "_win_col"}, 64'(win_col), 64'd0);
   endtask

   initial begin
      int budget;
      reset_n   = 1'b0;
      start     = 1'b0;
      pix_valid = 1'b0;
      pix_in    = 8'h00;
      win_ready = 1'b1;
      stall_arm = 1'b0;
      clear_caps();

      // Reset state, and idle refuses pixels.
      repeat (2) step();
      reset_n = 1'b1;
      chk_reset_outputs("rst");
      pix_valid = 1'b1;
      pix_in    = 8'hAA;
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("idle%0d_pix_ready", k), 64'(pix_ready), 64'd0);
      end
      pix_valid = 1'b0;

      // Continuous stream, consumer always ready.
      pulse_start();
      clear_caps();
      drive(NWIN, 0);
      drain();
      verify_frame("t1");
      chk("t1_idle_pix_ready", 64'(pix_ready), 64'd0);

      // Five-cycle backpressure on window (1,2).
      pulse_start();
      clear_caps();
      stall_arm = 1'b1;
      drive(NWIN, 0);
      drain();
      chk("t2_stall_seen", 64'(stall_arm), 64'd0);
      verify_frame("t2");

      // Random 50% input gaps.
      pulse_start();
      clear_caps();
      drive(NWIN, 50);
      drain();
      verify_frame("t3");

      // Reset after six accepted pixels, then a full frame.
      pulse_start();
      clear_caps();
      drive(6, 0);
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      chk_reset_outputs("mid_rst");
      pix_valid = 1'b1;
      pix_in    = 8'h55;
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("post_rst%0d_pix_ready", k), 64'(pix_ready), 64'd0);
      end
      pix_valid = 1'b0;
      pulse_start();
      clear_caps();
      drive(NWIN, 0);
      drain();
      verify_frame("t4");

      // Start during FLUSH after window (2,0) is taken.
      pulse_start();
      clear_caps();
      drive(NWIN, 0);
      budget = 0;
      while (cap_pix.size() < 9 && budget < 200) begin
         step();
         budget++;
      end
      chk("t5_pre_abort_count", 64'(cap_pix.size()), 64'd9);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("t5_abort_win_valid", 64'(win_valid), 64'd0);
      chk("t5_abort_pix_ready", 64'(pix_ready), 64'd1);
      repeat (3) step();
      chk("t5_abort_count", 64'(cap_pix.size()), 64'd9);
      chk("t5_abort_fd_cnt", 64'(fd_cnt), 64'd0);
      clear_caps();
      drive(NWIN, 0);
      drain();
      verify_frame("t5");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
- Converts a raster-order 8-bit luma pixel stream into 3x3 neighbourhood windows for the Sobel core.
- Produces exactly the 64-bit `inputPixels` packing, plus `row`/`col`, that the Sobel core consumes.
- Buffers two full lines internally and emits one window per image pixel.
- Sits between the grayscale converter and the Sobel core on the `clk` domain; out-of-image neighbours are zero (black border).

Parameters:
- H_PIXELS, 640, pixels per line (>=2).
- V_LINES, 480, lines per frame (>=2).
- CNT_W, 10, width of row/col counters and outputs.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse: abandon any frame in progress, arm for new frame.
- pix_in  in  8  input luma pixel, raster order.
- pix_valid  in  1  pix_in valid.
- pix_ready  out  1  block accepts pix_in this cycle (handshake = valid & ready).
- win_pixels  out  64  {NW,N,NE,W,E,SW,S,SE}, NW in [63:56], SE in [7:0]; centre pixel excluded.
- win_row  out  CNT_W  row of window centre.
- win_col  out  CNT_W  column of window centre.
- win_valid  out  1  window outputs valid.
- win_ready  in  1  consumer accepts window (handshake = valid & ready).
- frame_done  out  1  one-cycle pulse with handshake of window (V_LINES-1, H_PIXELS-1).

Behaviour:
- Reset (reset_n=0 at posedge): state IDLE; pix_ready=0, win_valid=0, frame_done=0; win_pixels, win_row, win_col = 0; counters cleared. Line-buffer contents are don't-care.
- Reset has priority over start, and start over all else. Reset or start mid-frame discards buffered data and any pending window.
- States:
  - IDLE: pix_ready=0; start -> FILL.
  - FILL: accept line 0 into line buffer; no windows; after pixel (0,H-1) -> RUN.
  - RUN: accept pixel (r+1,c). On accept with c>=1, register window centred (r,c-1) next cycle. After pixel (r+1,H-1) -> EOL.
  - EOL: pix_ready=0; emit window centred (r,H-1) with east column 0. -> RUN for the next line, or -> FLUSH after line V-1.
  - FLUSH: pix_ready=0; emit H windows for row V-1 with south row 0, then -> IDLE.
- Window for (r,c) (c<H-1, r<V-1) has win_valid high in the cycle after the handshake of pixel (r+1,c+1). Steady-state throughput is H+1 cycles per line.
- Padding: any neighbour with row<0, row>=V, col<0 or col>=H reads 0x00.
- Backpressure: single output register. When win_valid=1 and win_ready=0, hold all win_* stable, pix_ready=0, and freeze EOL/FLUSH progress.
- pix_ready = state in {FILL,RUN} and (win_valid=0 or win_ready=1).
- win_valid deasserts the cycle after a handshake unless a new window is loaded that same cycle.
- Counters wrap to 0 at H-1/V-1; no out-of-range row/col is ever driven. Pixels presented in IDLE are not accepted.
- Line buffers are two H_PIXELS x 8 arrays, rotated at each line end. No arithmetic on pixel data.

Optional Feature:
- Macro: SOBEL_WINDOW_REPLICATE_BORDER_EN.
- Defined: out-of-image neighbours take the nearest in-image pixel (edge replication, clamped row/col) instead of 0x00.
- Undefined: zero padding as above. Timing, handshakes and state machine are identical in both builds.

Test Plan:
- H=4, V=3, p(r,c)=16r+c+1, win_ready=1 -> 12 windows in raster order.
  - Centre (0,0) = 0x0000000002001112.
  - Centre (1,1) = 0x0102031113212223.
  - Centre (2,3) = 0x1314002300000000.
  - frame_done on the last window only.
- Same image with SOBEL_WINDOW_REPLICATE_BORDER_EN -> centre (0,0) = 0x0101020102111112.
- Hold win_ready=0 for 5 cycles at window (1,2) -> win_* stable, pix_ready=0 throughout; no window lost or duplicated; order unchanged.
- pix_valid toggled randomly at 50% -> window sequence identical to the first test; pix_ready=0 for exactly one cycle (EOL) after each line end from line 1 on.
- Assert reset_n=0 for one cycle after 6 pixels accepted -> all outputs 0 next cycle; pix_ready=0 until start; a full new frame then matches the first test.
- start pulse mid-FLUSH -> remaining row-2 windows dropped, state FILL, next frame correct, no frame_done for the aborted frame.
